// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control unit (optional Zbb CLZ/CTZ/CPOP).
// Decodes the instruction register one state at a time. Each state drives
// the memory handshake, the datapath selects, the write enables and the
// ALU function code.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   instr        instruction register contents
//   mem_ready    memory completes the current request this cycle
//   alu_cond     ALU result bit 0 (branch condition)
//   mem_req      memory request            mem_we    memory write
//   addr_sel     0 = PC, 1 = ALUOut        ir_we     instruction register write
//   pc_we        PC write                  pc_sel    0 = live ALU, 1 = ALUOut
//   reg_we       register file write       wb_sel    00 ALUOut, 01 mem, 11 PC
//   src1_sel     00 rs1, 01 PC, 10 old PC  src2_sel  00 rs2, 01 imm, 10 const 4
//   alu_func     5-bit ALU function code   illegal   high while halted
module mc_control #(
  parameter bit ENABLE_ZBB = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_cond,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  src1_sel,
  output logic [1:0]  src2_sel,
  output logic [4:0]  alu_func,
  output logic        illegal
);

  localparam int unsigned FW = 5;

  localparam logic [FW-1:0] ALU_AND  = 5'b0_0000;
  localparam logic [FW-1:0] ALU_OR   = 5'b0_0001;
  localparam logic [FW-1:0] ALU_XOR  = 5'b0_0010;
  localparam logic [FW-1:0] ALU_ADD  = 5'b0_0011;
  localparam logic [FW-1:0] ALU_SUB  = 5'b0_0100;
  localparam logic [FW-1:0] ALU_SLT  = 5'b0_0101;
  localparam logic [FW-1:0] ALU_LTU  = 5'b0_0110;
  localparam logic [FW-1:0] ALU_GEU  = 5'b0_0111;
  localparam logic [FW-1:0] ALU_GE   = 5'b0_1000;
  localparam logic [FW-1:0] ALU_EQ   = 5'b0_1001;
  localparam logic [FW-1:0] ALU_NE   = 5'b0_1010;
  localparam logic [FW-1:0] ALU_SRL  = 5'b0_1011;
  localparam logic [FW-1:0] ALU_SRA  = 5'b0_1100;
  localparam logic [FW-1:0] ALU_SLL  = 5'b0_1101;
  localparam logic [FW-1:0] ALU_PASS = 5'b0_1111;
  localparam logic [FW-1:0] ALU_CLZ  = 5'b1_0000;
  localparam logic [FW-1:0] ALU_CTZ  = 5'b1_0001;
  localparam logic [FW-1:0] ALU_CPOP = 5'b1_0010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_HALT
  } state_t;

  state_t state_q, state_d, decode_next;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm12;
  logic        zbb_hit;
  logic        r_legal, i_legal, mem_legal, br_legal;
  logic [FW-1:0] exec_func, br_func;
  logic        unused_instr;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm12  = instr[31:20];
  assign unused_instr = ^{instr[19:15], instr[11:7]};

  // CLZ/CTZ/CPOP share the OP-IMM funct3=001 slot via fixed upper bits
  assign zbb_hit = ENABLE_ZBB &&
                   ((imm12 == 12'h600) || (imm12 == 12'h601) || (imm12 == 12'h602));

  // Encoding legality, evaluated while in DECODE
  always_comb begin
    r_legal   = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    mem_legal = (funct3 == 3'b010);
    br_legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
    i_legal   = 1'b1;
    if (opcode == OPC_OP_IMM) begin
      if (funct3 == 3'b001)
        i_legal = (funct7 == F7_BASE) || zbb_hit;
      else if (funct3 == 3'b101)
        i_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
    end
  end

  // Opcode dispatch out of DECODE
  always_comb begin
    decode_next = S_HALT;
    case (opcode)
      OPC_OP:     decode_next = r_legal ? S_EXEC_R : S_HALT;
      OPC_OP_IMM: decode_next = i_legal ? S_EXEC_I : S_HALT;
      OPC_LUI:    decode_next = S_EXEC_I;
      OPC_LOAD,
      OPC_STORE:  decode_next = mem_legal ? S_ADDR : S_HALT;
      OPC_BRANCH: decode_next = br_legal ? S_BRANCH : S_HALT;
      OPC_JAL:    decode_next = S_JAL;
      OPC_JALR:   decode_next = S_JALR;
      OPC_AUIPC:  decode_next = S_WB_ALU;
      default:    decode_next = S_HALT;
    endcase
  end

  // ALU function for EXEC_R / EXEC_I; SUB only exists for register-register
  always_comb begin
    exec_func = ALU_ADD;
    case (funct3)
      3'b000: exec_func = ((opcode == OPC_OP) && (funct7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
      3'b001: begin
        exec_func = ALU_SLL;
        if ((opcode == OPC_OP_IMM) && zbb_hit) begin
          case (imm12[1:0])
            2'b00:   exec_func = ALU_CLZ;
            2'b01:   exec_func = ALU_CTZ;
            default: exec_func = ALU_CPOP;
          endcase
        end
      end
      3'b010: exec_func = ALU_SLT;
      3'b011: exec_func = ALU_LTU;
      3'b100: exec_func = ALU_XOR;
      3'b101: exec_func = instr[30] ? ALU_SRA : ALU_SRL;
      3'b110: exec_func = ALU_OR;
      default: exec_func = ALU_AND;
    endcase
    if (opcode == OPC_LUI) exec_func = ALU_PASS;
  end

  // Branch comparison select
  always_comb begin
    br_func = ALU_EQ;
    case (funct3)
      3'b001:  br_func = ALU_NE;
      3'b100:  br_func = ALU_SLT;
      3'b101:  br_func = ALU_GE;
      3'b110:  br_func = ALU_LTU;
      3'b111:  br_func = ALU_GEU;
      default: br_func = ALU_EQ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and per-state control outputs
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 2'b00;
    src1_sel = 2'b00;
    src2_sel = 2'b00;
    alu_func = ALU_ADD;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        src1_sel = 2'b01;
        src2_sel = 2'b10;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/JAL/AUIPC target: old PC + imm into ALUOut
        src1_sel = 2'b10;
        src2_sel = 2'b01;
        state_d  = decode_next;
      end
      S_EXEC_R: begin
        alu_func = exec_func;
        state_d  = S_WB_ALU;
      end
      S_EXEC_I: begin
        src2_sel = 2'b01;
        alu_func = exec_func;
        state_d  = S_WB_ALU;
      end
      S_ADDR: begin
        src2_sel = 2'b01;
        state_d  = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_ALU: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_WB_MEM: begin
        reg_we  = 1'b1;
        wb_sel  = 2'b01;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_func = br_func;
        pc_we    = alu_cond;
        pc_sel   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4, so it is the link value
        reg_we  = 1'b1;
        wb_sel  = 2'b11;
        pc_we   = 1'b1;
        pc_sel  = 1'b1;
        state_d = S_FETCH;
      end
      S_JALR: begin
        // Link captures the pre-edge PC while the live rs1+imm feeds the PC
        src2_sel = 2'b01;
        reg_we   = 1'b1;
        wb_sel   = 2'b11;
        pc_we    = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Reset silences every side effect immediately, not at the next edge
    if (!rst_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a per-cycle vector table for legal
// instruction flows, plus hand sequences for illegal encodings, the
// ENABLE_ZBB=0 build and asynchronous reset during a stalled store.
module tb_mc_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [1:0] src1_sel;
    logic [1:0] src2_sel;
    logic [4:0] alu_func;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic        rdy;
    logic        cond;
    out_t        exp;
  } vec_t;

  localparam logic [4:0] F_AND = 5'b00000, F_OR = 5'b00001, F_ADD = 5'b00011,
                         F_SUB = 5'b00100, F_SLT = 5'b00101, F_LTU = 5'b00110,
                         F_GEU = 5'b00111, F_GE = 5'b01000, F_EQ = 5'b01001,
                         F_NE = 5'b01010, F_SRL = 5'b01011, F_SRA = 5'b01100,
                         F_SLL = 5'b01101, F_PASS = 5'b01111, F_CLZ = 5'b10000,
                         F_CTZ = 5'b10001, F_CPOP = 5'b10010;

  logic        clk, rst_n, mem_ready, alu_cond;
  logic [31:0] instr;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, illegal;
  logic [1:0]  wb_sel, src1_sel, src2_sel;
  logic [4:0]  alu_func;
  logic        nz_mem_req, nz_mem_we, nz_addr_sel, nz_ir_we, nz_pc_we, nz_pc_sel;
  logic        nz_reg_we, nz_illegal;
  logic [1:0]  nz_wb_sel, nz_src1_sel, nz_src2_sel;
  logic [4:0]  nz_alu_func;

  int n_vec = 0;
  int n_err = 0;
  vec_t  vecs[$];
  string names[$];

  mc_control #(.ENABLE_ZBB(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_cond(alu_cond),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .src1_sel(src1_sel), .src2_sel(src2_sel), .alu_func(alu_func), .illegal(illegal)
  );

  mc_control #(.ENABLE_ZBB(1'b0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_cond(alu_cond),
    .mem_req(nz_mem_req), .mem_we(nz_mem_we), .addr_sel(nz_addr_sel), .ir_we(nz_ir_we),
    .pc_we(nz_pc_we), .pc_sel(nz_pc_sel), .reg_we(nz_reg_we), .wb_sel(nz_wb_sel),
    .src1_sel(nz_src1_sel), .src2_sel(nz_src2_sel), .alu_func(nz_alu_func),
    .illegal(nz_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t act_main();
    out_t o;
    o.mem_req = mem_req;   o.mem_we = mem_we;     o.addr_sel = addr_sel;
    o.ir_we = ir_we;       o.pc_we = pc_we;       o.pc_sel = pc_sel;
    o.reg_we = reg_we;     o.wb_sel = wb_sel;     o.src1_sel = src1_sel;
    o.src2_sel = src2_sel; o.alu_func = alu_func; o.illegal = illegal;
    return o;
  endfunction

  function automatic out_t act_nz();
    out_t o;
    o.mem_req = nz_mem_req;   o.mem_we = nz_mem_we;     o.addr_sel = nz_addr_sel;
    o.ir_we = nz_ir_we;       o.pc_we = nz_pc_we;       o.pc_sel = nz_pc_sel;
    o.reg_we = nz_reg_we;     o.wb_sel = nz_wb_sel;     o.src1_sel = nz_src1_sel;
    o.src2_sel = nz_src2_sel; o.alu_func = nz_alu_func; o.illegal = nz_illegal;
    return o;
  endfunction

  // Expected per-state outputs, written directly from the state descriptions
  function automatic out_t o_base();
    out_t o = '0;
    o.alu_func = F_ADD;
    return o;
  endfunction
  function automatic out_t o_fetch(input logic rdy);
    out_t o = o_base();
    o.mem_req = 1'b1; o.ir_we = rdy; o.pc_we = rdy;
    o.src1_sel = 2'b01; o.src2_sel = 2'b10;
    return o;
  endfunction
  function automatic out_t o_decode();
    out_t o = o_base();
    o.src1_sel = 2'b10; o.src2_sel = 2'b01;
    return o;
  endfunction
  function automatic out_t o_exec(input logic [4:0] f, input logic imm);
    out_t o = o_base();
    o.alu_func = f; o.src2_sel = imm ? 2'b01 : 2'b00;
    return o;
  endfunction
  function automatic out_t o_addr();
    out_t o = o_base();
    o.src2_sel = 2'b01;
    return o;
  endfunction
  function automatic out_t o_mem(input logic wr);
    out_t o = o_base();
    o.mem_req = 1'b1; o.mem_we = wr; o.addr_sel = 1'b1;
    return o;
  endfunction
  function automatic out_t o_wb(input logic [1:0] sel);
    out_t o = o_base();
    o.reg_we = 1'b1; o.wb_sel = sel;
    return o;
  endfunction
  function automatic out_t o_branch(input logic [4:0] f, input logic c);
    out_t o = o_base();
    o.alu_func = f; o.pc_we = c; o.pc_sel = 1'b1;
    return o;
  endfunction
  function automatic out_t o_jal();
    out_t o = o_base();
    o.reg_we = 1'b1; o.wb_sel = 2'b11; o.pc_we = 1'b1; o.pc_sel = 1'b1;
    return o;
  endfunction
  function automatic out_t o_jalr();
    out_t o = o_base();
    o.src2_sel = 2'b01; o.reg_we = 1'b1; o.wb_sel = 2'b11; o.pc_we = 1'b1;
    return o;
  endfunction
  function automatic out_t o_halt();
    out_t o = o_base();
    o.illegal = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, act[18:0], exp[18:0]);
    end
  endtask

  task automatic push(input string n, input logic [31:0] ins, input logic rdy,
                      input logic cond, input out_t e);
    vec_t v;
    v.instr = ins; v.rdy = rdy; v.cond = cond; v.exp = e;
    vecs.push_back(v);
    names.push_back(n);
  endtask

  task automatic push_alu(input string n, input logic [31:0] ins, input logic [4:0] f,
                          input logic imm);
    push({n, ".fetch"},  ins, 1'b1, 1'b0, o_fetch(1'b1));
    push({n, ".decode"}, ins, 1'b1, 1'b0, o_decode());
    push({n, ".exec"},   ins, 1'b1, 1'b0, o_exec(f, imm));
    push({n, ".wb"},     ins, 1'b1, 1'b0, o_wb(2'b00));
  endtask

  task automatic push_br(input string n, input logic [31:0] ins, input logic [4:0] f,
                         input logic c);
    push({n, ".fetch"},  ins, 1'b1, c, o_fetch(1'b1));
    push({n, ".decode"}, ins, 1'b1, c, o_decode());
    push({n, ".branch"}, ins, 1'b1, c, o_branch(f, c));
  endtask

  // Drive inputs at a falling edge and let combinational outputs settle
  task automatic drive(input logic [31:0] ins, input logic rdy, input logic cond);
    instr = ins; mem_ready = rdy; alu_cond = cond;
    #1;
  endtask

  // Enters and leaves on a falling edge; checks the forced-off outputs
  task automatic do_reset(input string n);
    rst_n = 1'b0; mem_ready = 1'b0; alu_cond = 1'b0;
    #1;
    check({n, ".rst_forced"},
          32'({mem_req, mem_we, ir_we, pc_we, reg_we, illegal}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] bad_instrs[6];

  initial begin
    rst_n = 1'b0; instr = 32'h0; mem_ready = 1'b0; alu_cond = 1'b0;

    // Per-cycle vector table, starting from FETCH after reset
    push_alu("add", 32'h002081B3, F_ADD, 1'b0);
    push("sub.fetchwait", 32'h402081B3, 1'b0, 1'b0, o_fetch(1'b0));
    push_alu("sub",   32'h402081B3, F_SUB,  1'b0);
    push_alu("sra",   32'h4020D1B3, F_SRA,  1'b0);
    push_alu("srl",   32'h0020D1B3, F_SRL,  1'b0);
    push_alu("and",   32'h0020F1B3, F_AND,  1'b0);
    push_alu("sltu",  32'h0020B1B3, F_LTU,  1'b0);
    push_alu("addi",  32'h00508093, F_ADD,  1'b1);
    push_alu("slli",  32'h00309093, F_SLL,  1'b1);
    push_alu("srai",  32'h4030D093, F_SRA,  1'b1);
    push_alu("ori",   32'h0050E093, F_OR,   1'b1);
    push_alu("lui",   32'h123450B7, F_PASS, 1'b1);
    push_alu("clz",   32'h60009093, F_CLZ,  1'b1);
    push_alu("ctz",   32'h60109093, F_CTZ,  1'b1);
    push_alu("cpop",  32'h60209093, F_CPOP, 1'b1);
    push("auipc.fetch",  32'h00001097, 1'b1, 1'b0, o_fetch(1'b1));
    push("auipc.decode", 32'h00001097, 1'b1, 1'b0, o_decode());
    push("auipc.wb",     32'h00001097, 1'b1, 1'b0, o_wb(2'b00));
    push("jal.fetch",    32'h008000EF, 1'b1, 1'b0, o_fetch(1'b1));
    push("jal.decode",   32'h008000EF, 1'b1, 1'b0, o_decode());
    push("jal.jal",      32'h008000EF, 1'b1, 1'b0, o_jal());
    push("jalr.fetch",   32'h000080E7, 1'b1, 1'b0, o_fetch(1'b1));
    push("jalr.decode",  32'h000080E7, 1'b1, 1'b0, o_decode());
    push("jalr.jalr",    32'h000080E7, 1'b1, 1'b0, o_jalr());
    push_br("beq0", 32'h00208463, F_EQ,  1'b0);
    push_br("beq1", 32'h00208463, F_EQ,  1'b1);
    push_br("bne",  32'h00209463, F_NE,  1'b1);
    push_br("blt",  32'h0020C463, F_SLT, 1'b0);
    push_br("bge",  32'h0020D463, F_GE,  1'b1);
    push_br("bltu", 32'h0020E463, F_LTU, 1'b1);
    push_br("bgeu", 32'h0020F463, F_GEU, 1'b0);
    push("sw.fetch",  32'h0020A223, 1'b1, 1'b0, o_fetch(1'b1));
    push("sw.decode", 32'h0020A223, 1'b1, 1'b0, o_decode());
    push("sw.addr",   32'h0020A223, 1'b1, 1'b0, o_addr());
    push("sw.memwr",  32'h0020A223, 1'b1, 1'b0, o_mem(1'b1));
    push("lw.fetch",  32'h0000A183, 1'b1, 1'b0, o_fetch(1'b1));
    push("lw.decode", 32'h0000A183, 1'b1, 1'b0, o_decode());
    push("lw.addr",   32'h0000A183, 1'b1, 1'b0, o_addr());
    for (int i = 0; i < 3; i++)
      push("lw.memrd_wait", 32'h0000A183, 1'b0, 1'b0, o_mem(1'b0));
    push("lw.memrd",  32'h0000A183, 1'b1, 1'b0, o_mem(1'b0));
    push("lw.wbmem",  32'h0000A183, 1'b1, 1'b0, o_wb(2'b01));
    push("lw.next_fetch", 32'h0000A183, 1'b0, 1'b0, o_fetch(1'b0));

    @(negedge clk);
    do_reset("init");
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].instr, vecs[i].rdy, vecs[i].cond);
      check(names[i], 32'(act_main()), 32'(vecs[i].exp));
      @(negedge clk);
    end

    // Illegal encodings halt out of DECODE and stay halted until reset
    bad_instrs[0] = 32'h022081B3;  // R-type funct7=0000001
    bad_instrs[1] = 32'h402091B3;  // funct7=0100000 with funct3=001
    bad_instrs[2] = 32'h00008183;  // load with funct3=000
    bad_instrs[3] = 32'h02009093;  // shift-immediate bad upper bits
    bad_instrs[4] = 32'h0020A463;  // branch funct3=010
    bad_instrs[5] = 32'h0000007F;  // unknown opcode
    for (int b = 0; b < 6; b++) begin
      do_reset("illegal");
      drive(bad_instrs[b], 1'b1, 1'b0);
      check("illegal.fetch", 32'(act_main()), 32'(o_fetch(1'b1)));
      @(negedge clk);
      drive(bad_instrs[b], 1'b1, 1'b0);
      check("illegal.decode", 32'(act_main()), 32'(o_decode()));
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        drive(32'h002081B3, 1'(c), 1'b1);
        check("illegal.halt", 32'(act_main()), 32'(o_halt()));
        @(negedge clk);
      end
    end

    // ENABLE_ZBB=0 build: CLZ halts; illegal holds until reset
    do_reset("nozbb");
    drive(32'h60009093, 1'b1, 1'b0);
    check("nozbb.fetch", 32'(act_nz()), 32'(o_fetch(1'b1)));
    @(negedge clk);
    drive(32'h60009093, 1'b1, 1'b0);
    check("nozbb.decode", 32'(act_nz()), 32'(o_decode()));
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      drive(32'h60009093, 1'(c), 1'b0);
      check("nozbb.halt", 32'(act_nz()), 32'(o_halt()));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("nozbb.rst_illegal", 32'(nz_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h60009093, 1'b0, 1'b0);
    check("nozbb.after_rst", 32'(act_nz()), 32'(o_fetch(1'b0)));
    @(negedge clk);

    // Reset asserted mid-cycle during a stalled store
    do_reset("swrst");
    drive(32'h0020A223, 1'b1, 1'b0);
    check("swrst.fetch", 32'(act_main()), 32'(o_fetch(1'b1)));
    @(negedge clk);
    drive(32'h0020A223, 1'b1, 1'b0);
    check("swrst.decode", 32'(act_main()), 32'(o_decode()));
    @(negedge clk);
    drive(32'h0020A223, 1'b1, 1'b0);
    check("swrst.addr", 32'(act_main()), 32'(o_addr()));
    @(negedge clk);
    drive(32'h0020A223, 1'b0, 1'b0);
    check("swrst.memwr_wait", 32'(act_main()), 32'(o_mem(1'b1)));
    #1;
    rst_n = 1'b0;
    #1;
    check("swrst.async_drop", 32'({mem_req, mem_we, ir_we, pc_we, reg_we, illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0020A223, 1'b0, 1'b0);
    check("swrst.after_rst", 32'(act_main()), 32'(o_fetch(1'b0)));
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
